bus_master: RTL and testbench

// - Upstream initiator for the req/ack register slave: accepts read/write commands from a

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_timeout_cnt.sv | 31 +++
 rtl/bus_master.sv | 122 ++++++++++++
 tb/tb_bus_master.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the req/ack bus master.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  localparam int unsigned ADDR_MAX_DEFAULT = 100;
  localparam int unsigned TIMEOUT_DEFAULT  = 16;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating cycle counter with clear/enable; expired flags the last allowed cycle.
module bus_timeout_cnt
  import bus_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] SAT_CNT = W'(LIMIT);
  localparam logic [W-1:0] EXP_CNT = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Count enabled cycles, restart on clear, hold at LIMIT instead of wrapping
  always_ff @(posedge clk) begin
    if (arst || clr) begin
      count <= '0;
    end else if (en && (count != SAT_CNT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count >= EXP_CNT);

endmodule

// File: rtl/bus_master.sv
// Host-command to 4-phase req/ack bus initiator with range check and ack timeouts.
module bus_master
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_MAX = ADDR_MAX_DEFAULT,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        h_valid,
  output logic        h_ready,
  input  logic        h_cmd,
  input  logic [31:0] h_addr,
  input  logic [31:0] h_wdata,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_rdata,
  output logic        r_err,
  output logic        req,
  output logic        cmd,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        ack,
  input  logic [31:0] rdata
);

  localparam logic [31:0] ADDR_LIMIT = ADDR_MAX;

  state_t state;
  logic   leave;
  logic   expired;
  logic   cnt_en;

  // Flag the cycle in which the FSM will change state so the timer restarts per state
  always_comb begin
    leave = 1'b0;
    case (state)
      IDLE:    leave = h_valid;
      REQ:     leave = ack || expired;
      DROP:    leave = !ack || expired;
      RESP:    leave = r_ready;
      default: leave = 1'b1;
    endcase
  end

  assign cnt_en  = (state == REQ) || (state == DROP);
  assign h_ready = (state == IDLE);

  bus_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .arst   (arst),
    .clr    (leave),
    .en     (cnt_en),
    .expired(expired)
  );

  // Transaction FSM: every bus and response output is registered here
  always_ff @(posedge clk) begin
    if (arst) begin
      state   <= IDLE;
      req     <= 1'b0;
      cmd     <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (h_valid) begin
            cmd     <= h_cmd;
            addr    <= h_addr;
            wdata   <= h_wdata;
            r_rdata <= '0;
            if (h_addr > ADDR_LIMIT) begin
              r_err   <= 1'b1;
              r_valid <= 1'b1;
              state   <= RESP;
            end else begin
              r_err <= 1'b0;
              req   <= 1'b1;
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (ack) begin
            r_rdata <= (cmd == CMD_WR) ? 32'd0 : rdata;
            req     <= 1'b0;
            state   <= DROP;
          end else if (expired) begin
            req   <= 1'b0;
            r_err <= 1'b1;
            state <= DROP;
          end
        end
        DROP: begin
          if (!ack) begin
            r_valid <= 1'b1;
            state   <= RESP;
          end else if (expired) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_valid <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master with a behavioural slave and fault modes.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        arst;
  logic        h_valid;
  logic        h_ready;
  logic        h_cmd;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        req;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;

  // 0 = normal slave, 1 = ack stuck low, 2 = ack sticks high once raised
  int slave_mode = 0;
  logic [31:0] slave_mem [0:127];
  logic [31:0] ref_mem [int];
  logic        req_prev = 1'b0;

  bus_master dut (
    .clk    (clk),
    .arst   (arst),
    .h_valid(h_valid),
    .h_ready(h_ready),
    .h_cmd  (h_cmd),
    .h_addr (h_addr),
    .h_wdata(h_wdata),
    .r_valid(r_valid),
    .r_ready(r_ready),
    .r_rdata(r_rdata),
    .r_err  (r_err),
    .req    (req),
    .cmd    (cmd),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Slave model: ack registered one cycle after req, memory access on the req rise
  always @(posedge clk) begin
    if (arst) begin
      ack <= 1'b0;
    end else begin
      case (slave_mode)
        1: ack <= 1'b0;
        2: if (req) ack <= 1'b1;
        default: ack <= req;
      endcase
      if (slave_mode == 0 && req && !ack) begin
        rdata <= slave_mem[addr[6:0]];
        if (cmd) slave_mem[addr[6:0]] <= wdata;
      end
    end
  end

  // Return-to-zero check on every req rise
  always @(negedge clk) begin
    if (req && !req_prev) begin
      compared++;
      if (ack) begin
        failed++;
        $display("[TB] FAIL req_rise_with_ack: ack=%0b required 0 at cycle %0d", ack, cyc);
      end
    end
    req_prev = req;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic        c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic void refModel(input logic c, input logic [31:0] a, input logic [31:0] d,
                                   output logic [31:0] rd, output logic er);
    if (a > 32'd100) begin
      er = 1'b1;
      rd = 32'd0;
    end else begin
      er = 1'b0;
      if (c) begin
        ref_mem[int'(a)] = d;
        rd = 32'd0;
      end else begin
        rd = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'd0;
      end
    end
  endfunction

  // Present one command and return the cycle in which it was accepted
  task automatic applyStimulus(input logic c, input logic [31:0] a, input logic [31:0] d,
                               output int acc);
    @(negedge clk);
    h_valid = 1'b1;
    h_cmd   = c;
    h_addr  = a;
    h_wdata = d;
    acc = -1;
    for (int n = 0; n < 100; n++) begin
      if (h_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      compared++;
      failed++;
      $display("[TB] FAIL accept_timeout: h_ready never seen");
    end
    @(posedge clk);
    @(negedge clk);
    h_valid = 1'b0;
  endtask

  task automatic waitResponse(input int acc, output logic [31:0] rd, output logic er,
                              output int lat, output int req_hi);
    bit seen = 0;
    req_hi = 0;
    rd = '0;
    er = 1'b0;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      if (r_valid) begin
        rd = r_rdata;
        er = r_err;
        lat = cyc - acc;
        seen = 1;
        break;
      end
      if (req) req_hi++;
      @(negedge clk);
    end
    if (!seen) begin
      compared++;
      failed++;
      $display("[TB] FAIL resp_timeout: r_valid not seen within 100 cycles");
    end
  endtask

  task automatic doCommand(input string tag, input logic c, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    int acc, lat, req_hi;
    logic [31:0] rd;
    logic er;
    applyStimulus(c, a, d, acc);
    waitResponse(acc, rd, er, lat, req_hi);
    checkOutput({tag, "_rdata"}, rd, exp_rd);
    checkOutput({tag, "_err"}, 32'(er), 32'(exp_err));
    if (exp_err) begin
      checkOutput({tag, "_lat_ok"}, 32'(lat >= 1 && lat <= 2), 32'd1);
      checkOutput({tag, "_req_cycles"}, 32'(req_hi), 32'd0);
    end else begin
      checkOutput({tag, "_lat"}, 32'(lat), 32'd5);
      checkOutput({tag, "_req_cycles"}, 32'(req_hi), 32'd2);
    end
  endtask

  initial begin
    vec_t vecs [8];
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int acc, lat, req_hi;

    for (int i = 0; i < 128; i++) slave_mem[i] = 32'd0;
    arst = 1'b1;
    h_valid = 1'b0;
    h_cmd = 1'b0;
    h_addr = '0;
    h_wdata = '0;
    r_ready = 1'b1;

    vecs[0] = '{1'b1, 32'd5,   32'hDEADBEEF, 32'd0,         1'b0};
    vecs[1] = '{1'b0, 32'd5,   32'd0,        32'hDEADBEEF,  1'b0};
    vecs[2] = '{1'b0, 32'd101, 32'd0,        32'd0,         1'b1};
    vecs[3] = '{1'b1, 32'd100, 32'h12345678, 32'd0,         1'b0};
    vecs[4] = '{1'b0, 32'd100, 32'd0,        32'h12345678,  1'b0};
    vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'd0,    1'b1};
    vecs[6] = '{1'b0, 32'd0,   32'd0,        32'd0,         1'b0};
    vecs[7] = '{1'b0, 32'h80000000, 32'd0,   32'd0,         1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    checkOutput("rst_h_ready", 32'(h_ready), 32'd1);
    checkOutput("rst_req",     32'(req),     32'd0);
    checkOutput("rst_r_valid", 32'(r_valid), 32'd0);
    checkOutput("rst_r_err",   32'(r_err),   32'd0);
    checkOutput("rst_r_rdata", r_rdata,      32'd0);
    checkOutput("rst_addr",    addr,         32'd0);
    checkOutput("rst_wdata",   wdata,        32'd0);
    checkOutput("rst_cmd",     32'(cmd),     32'd0);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      refModel(vecs[i].c, vecs[i].a, vecs[i].d, exp_rd, exp_er);
      doCommand($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].d,
                vecs[i].exp_rd, vecs[i].exp_err);
    end

    $display("[TB] ack stuck low");
    slave_mode = 1;
    applyStimulus(1'b0, 32'd3, 32'd0, acc);
    waitResponse(acc, rd, er, lat, req_hi);
    checkOutput("tmo_req_cycles", 32'(req_hi), 32'd16);
    checkOutput("tmo_err", 32'(er), 32'd1);
    checkOutput("tmo_rdata", rd, 32'd0);
    slave_mode = 0;
    refModel(1'b1, 32'd7, 32'h0BADF00D, exp_rd, exp_er);
    doCommand("tmo_next", 1'b1, 32'd7, 32'h0BADF00D, exp_rd, exp_er);

    $display("[TB] ack stuck high");
    slave_mode = 2;
    applyStimulus(1'b0, 32'd4, 32'd0, acc);
    waitResponse(acc, rd, er, lat, req_hi);
    checkOutput("stk_req_cycles", 32'(req_hi), 32'd2);
    checkOutput("stk_lat", 32'(lat), 32'd19);
    checkOutput("stk_err", 32'(er), 32'd1);
    checkOutput("stk_rdata", rd, 32'd0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("stk_no_rereq", 32'(req), 32'd0);
    end
    slave_mode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] response back-pressure");
    r_ready = 1'b0;
    refModel(1'b0, 32'd5, 32'd0, exp_rd, exp_er);
    applyStimulus(1'b0, 32'd5, 32'd0, acc);
    waitResponse(acc, rd, er, lat, req_hi);
    checkOutput("bp_lat", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_r_valid", 32'(r_valid), 32'd1);
      checkOutput("bp_r_rdata", r_rdata, exp_rd);
      checkOutput("bp_r_err",   32'(r_err), 32'(exp_er));
      checkOutput("bp_h_ready", 32'(h_ready), 32'd0);
      checkOutput("bp_req",     32'(req), 32'd0);
    end
    r_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_r_valid", 32'(r_valid), 32'd0);
    checkOutput("bp_release_h_ready", 32'(h_ready), 32'd1);

    $display("[TB] reset during REQ");
    slave_mode = 1;
    applyStimulus(1'b1, 32'd9, 32'h11112222, acc);
    checkOutput("mid_req_before", 32'(req), 32'd1);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    checkOutput("mid_req_after", 32'(req), 32'd0);
    checkOutput("mid_h_ready", 32'(h_ready), 32'd1);
    slave_mode = 0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("mid_no_resp", 32'(r_valid), 32'd0);
      @(negedge clk);
    end
    refModel(1'b1, 32'd0, 32'hCAFEF00D, exp_rd, exp_er);
    doCommand("mid_wr0", 1'b1, 32'd0, 32'hCAFEF00D, exp_rd, exp_er);
    refModel(1'b0, 32'd0, 32'd0, exp_rd, exp_er);
    doCommand("mid_rd0", 1'b0, 32'd0, 32'd0, exp_rd, exp_er);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      logic        c;
      logic [31:0] a, d;
      c = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 110));
      d = $urandom;
      refModel(c, a, d, exp_rd, exp_er);
      doCommand($sformatf("rnd%0d", i), c, a, d, exp_rd, exp_er);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
